// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction memory req/ack, decode valid/ready and branch redirect.
// master = fetch unit, slave = memory/decode/branch side.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  opcode;
  logic [15:0] instr_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] fetch_count;
  logic        halted;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, fetch_count, halted,
    input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, instr_pc, fetch_count, halted,
    output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/ack, presents words over valid/ready.
// Optional halt-opcode detection is enabled by defining HALT_DETECT_EN.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [2:0]  HALT_OPCODE = 3'b110
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
`ifdef HALT_DETECT_EN
    , S_HALT = 2'd3
`endif
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic        r_drop;
  logic        r_req;
  logic [15:0] r_addr;
  logic        r_valid;
  logic [15:0] r_instr;
  logic [2:0]  r_opcode;
  logic [15:0] r_instr_pc;
  logic [15:0] r_count;
  logic [15:0] w_target;

  assign w_target = bus.redirect_pc & 16'hFFFE;

  // Fetch FSM; redirect outranks every other event in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC & 16'hFFFE;
      r_drop     <= 1'b0;
      r_req      <= 1'b0;
      r_addr     <= 16'h0000;
      r_valid    <= 1'b0;
      r_instr    <= 16'h0000;
      r_opcode   <= 3'b000;
      r_instr_pc <= 16'h0000;
      r_count    <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req   <= 1'b1;
          r_state <= S_FETCH;
          if (bus.redirect) begin
            r_pc   <= w_target;
            r_addr <= w_target;
          end else begin
            r_addr <= r_pc;
          end
        end
        S_FETCH: begin
          if (bus.redirect) begin
            r_pc <= w_target;
            // An in-flight request must still complete at its old address, so remember to drop it.
            if (bus.imem_ack) begin
              r_addr <= w_target;
              r_drop <= 1'b0;
            end else begin
              r_drop <= 1'b1;
            end
          end else if (bus.imem_ack) begin
            if (r_drop) begin
              r_drop <= 1'b0;
              r_addr <= r_pc;
            end else begin
              r_instr    <= bus.imem_rdata;
              r_opcode   <= bus.imem_rdata[15:13];
              r_instr_pc <= r_addr;
              r_valid    <= 1'b1;
              r_pc       <= r_addr + 16'd2;
              r_req      <= 1'b0;
              r_state    <= S_VALID;
            end
          end else begin
            r_req <= 1'b1;
          end
        end
        S_VALID: begin
          if (bus.redirect) begin
            r_valid <= 1'b0;
            r_pc    <= w_target;
            r_req   <= 1'b1;
            r_addr  <= w_target;
            r_state <= S_FETCH;
          end else if (bus.instr_ready) begin
            r_count <= r_count + 16'd1;
            r_valid <= 1'b0;
`ifdef HALT_DETECT_EN
            if (r_opcode == HALT_OPCODE) begin
              r_state <= S_HALT;
            end else
`endif
            begin
              r_req   <= 1'b1;
              r_addr  <= r_pc;
              r_state <= S_FETCH;
            end
          end else begin
            r_valid <= 1'b1;
          end
        end
`ifdef HALT_DETECT_EN
        S_HALT: begin
          if (bus.redirect) begin
            r_pc    <= w_target;
            r_req   <= 1'b1;
            r_addr  <= w_target;
            r_state <= S_FETCH;
          end else begin
            r_req <= 1'b0;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instr_valid = r_valid;
  assign bus.instr       = r_instr;
  assign bus.opcode      = r_opcode;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.fetch_count = r_count;

`ifdef HALT_DETECT_EN
  logic r_halted;

  // Halt flag mirrors the HALT state so it is a plain registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
    end else if (r_state == S_VALID && !bus.redirect && bus.instr_ready && r_opcode == HALT_OPCODE) begin
      r_halted <= 1'b1;
    end else if (r_state == S_HALT && bus.redirect) begin
      r_halted <= 1'b0;
    end else begin
      r_halted <= r_halted;
    end
  end

  assign bus.halted = r_halted;
`else
  logic w_unused_halt_opcode;
  assign w_unused_halt_opcode = ^HALT_OPCODE;
  assign bus.halted = 1'b0;
`endif

endmodule
